// File: rtl/nand_reduce_pipe_if.sv
// Handshake bundle for the pipelined lane-reduction unit: input beat, result beat,
// and the mode that travels with each beat.
interface nand_reduce_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [1:0]                in_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS-1:0]       out_data;
  logic [1:0]                out_mode;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/nand_reduce_pipe.sv
// Pipelined per-lane AND/OR reduction tree with optional final inversion (NAND/NOR),
// a register bank every LPS tree levels and a single global stall.
module nand_reduce_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int LPS      = 2
) (
  input logic             clk,
  input logic             rst,
  nand_reduce_pipe_if.slave bus
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int PW    = 1 << LOG2W;
  localparam int L     = (LOG2W + LPS - 1) / LPS;

  logic                         advance;
  logic                         out_valid_q;
  logic [CHANNELS-1:0]          out_data_q;
  logic [1:0]                   out_mode_q;
  logic [CHANNELS-1:0][PW-1:0]  pad_lanes;

  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mode  = out_mode_q;

  // Pad bits take the identity of the tree operator so they never change the result.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      pad_lanes[c] = {PW{~bus.in_mode[1]}};
      for (int i = 0; i < WIDTH; i++) begin
        pad_lanes[c][i] = bus.in_data[c*WIDTH + i];
      end
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int LO  = s * LPS;
    localparam int HI  = ((s + 1) * LPS < LOG2W) ? (s + 1) * LPS : LOG2W;
    localparam int NLV = HI - LO;
    localparam int WIN = PW >> LO;

    logic [CHANNELS-1:0][WIN-1:0] src;
    logic [1:0]                   src_mode;
    logic                         src_vld;

    if (s == 0) begin : g_head
      assign src      = pad_lanes;
      assign src_mode = bus.in_mode;
      assign src_vld  = bus.in_valid;
    end else begin : g_link
      assign src      = g_stage[s-1].g_mid.res_q;
      assign src_mode = g_stage[s-1].g_mid.mode_q;
      assign src_vld  = g_stage[s-1].g_mid.vld_q;
    end

    for (genvar k = 0; k <= NLV; k++) begin : g_lv
      logic [CHANNELS-1:0][(WIN>>k)-1:0] v;
      if (k == 0) begin : g_leaf
        assign v = src;
      end else begin : g_node
        always_comb begin
          for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < (WIN >> k); i++) begin
              v[c][i] = src_mode[1] ? (g_lv[k-1].v[c][2*i] | g_lv[k-1].v[c][2*i+1])
                                    : (g_lv[k-1].v[c][2*i] & g_lv[k-1].v[c][2*i+1]);
            end
          end
        end
      end
    end

    if (s < L - 1) begin : g_mid
      logic [CHANNELS-1:0][(WIN>>NLV)-1:0] res_d, res_q;
      logic [1:0]                          mode_q;
      logic                                vld_q;

      assign res_d = g_lv[NLV].v;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          res_q  <= '0;
          mode_q <= 2'b00;
        end else if (advance) begin
          vld_q <= src_vld;
          if (src_vld) begin
            res_q  <= res_d;
            mode_q <= src_mode;
          end
        end
      end
    end else begin : g_last
      logic [CHANNELS-1:0] res_d;

      // Modes 00/10 are the inverting variants.
      assign res_d = g_lv[NLV].v ^ {CHANNELS{~src_mode[0]}};

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_mode_q  <= 2'b00;
        end else if (advance) begin
          out_valid_q <= src_vld;
          if (src_vld) begin
            out_data_q <= res_d;
            out_mode_q <= src_mode;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Scoreboard bench for nand_reduce_pipe: three configurations (2x1/L=1, 8x4/L=2, 5x1/L=3).
module tb_nand_reduce_pipe;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;
  localparam int LAT_C = 3;

  typedef struct {
    logic [3:0] data;
    logic [1:0] mode;
    int         acc;
    bit         lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;
  bit   ovlog [4096];
  sb_t  q_a[$];
  sb_t  q_b[$];
  sb_t  q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nand_reduce_pipe_if #(.WIDTH(2), .CHANNELS(1)) ifa ();
  nand_reduce_pipe_if #(.WIDTH(8), .CHANNELS(4)) ifb ();
  nand_reduce_pipe_if #(.WIDTH(5), .CHANNELS(1)) ifc ();

  nand_reduce_pipe #(.WIDTH(2), .CHANNELS(1), .LPS(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  nand_reduce_pipe #(.WIDTH(8), .CHANNELS(4), .LPS(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  nand_reduce_pipe #(.WIDTH(5), .CHANNELS(1), .LPS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    if (d == 0) return q_a.size();
    if (d == 1) return q_b.size();
    return q_c.size();
  endfunction

  task automatic pop_chk(input int d, input logic [3:0] od, input logic [1:0] om);
    sb_t e;
    bit  got;
    int  lat;
    got = 0;
    e   = '{data: 4'h0, mode: 2'b00, acc: 0, lat: 1'b0};
    if (d == 0 && q_a.size() > 0) begin e = q_a.pop_front(); got = 1; end
    if (d == 1 && q_b.size() > 0) begin e = q_b.pop_front(); got = 1; end
    if (d == 2 && q_c.size() > 0) begin e = q_c.pop_front(); got = 1; end
    lat = (d == 0) ? LAT_A : (d == 1) ? LAT_B : LAT_C;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL unexpected_out dut%0d: got data %0h, required no result", d, od);
    end else begin
      chk($sformatf("out_data dut%0d", d), 32'(od), 32'(e.data));
      chk($sformatf("out_mode dut%0d", d), 32'(om), 32'(e.mode));
      if (e.lat) chk($sformatf("latency dut%0d", d), 32'(cyc - e.acc), 32'(lat));
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready) pop_chk(0, {3'b000, ifa.out_data}, ifa.out_mode);
    if (!rst && ifc.out_valid && ifc.out_ready) pop_chk(2, {3'b000, ifc.out_data}, ifc.out_mode);
  end

  logic       stall_p = 1'b0;
  logic [3:0] data_p;
  logic [1:0] mode_p;

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_hold_valid", 32'(ifb.out_valid), 32'd1);
        chk("stall_hold_data", 32'(ifb.out_data), 32'(data_p));
        chk("stall_hold_mode", 32'(ifb.out_mode), 32'(mode_p));
      end
      chk("in_ready_rule", 32'(ifb.in_ready), 32'(!(ifb.out_valid && !ifb.out_ready)));
      if (ifb.out_valid && ifb.out_ready) pop_chk(1, ifb.out_data, ifb.out_mode);
      if (ifb.out_valid && !ifb.out_ready) stall_cnt++;
      stall_p = ifb.out_valid && !ifb.out_ready;
      data_p  = ifb.out_data;
      mode_p  = ifb.out_mode;
      if (cyc < 4096) ovlog[cyc] = ifb.out_valid;
    end
  end

  task automatic set_in(input int d, input logic v, input logic [31:0] data, input logic [1:0] mode);
    if (d == 0) begin ifa.in_valid = v; ifa.in_data = data[1:0]; ifa.in_mode = mode; end
    if (d == 1) begin ifb.in_valid = v; ifb.in_data = data;      ifb.in_mode = mode; end
    if (d == 2) begin ifc.in_valid = v; ifc.in_data = data[4:0]; ifc.in_mode = mode; end
  endtask

  task automatic send(input int d, input logic [31:0] data, input logic [1:0] mode,
                      input logic [3:0] exp, input bit lat, output int acc);
    bit  done;
    bit  rdy;
    sb_t e;
    done = 0;
    acc  = -1;
    set_in(d, 1'b1, data, mode);
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      rdy = (d == 0) ? ifa.in_ready : (d == 1) ? ifb.in_ready : ifc.in_ready;
      if (rdy) begin
        done = 1;
        acc  = cyc;
        e    = '{data: exp, mode: mode, acc: cyc, lat: lat};
        if (d == 0) q_a.push_back(e);
        if (d == 1) q_b.push_back(e);
        if (d == 2) q_c.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1 within 100 cycles", d);
    end
    set_in(d, 1'b0, data, mode);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (qsize(d) > 0 && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk($sformatf("drain_left dut%0d", d), 32'(qsize(d)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int e0;
    int s0;
    logic [31:0] bp_data [6];
    logic [1:0]  bp_mode [6];
    logic [3:0]  bp_exp  [6];
    logic [1:0]  a_exp   [4];
    bp_data = '{32'h00FF0F01, 32'h00FF0F01, 32'h00FF0F01, 32'h00FF0F01, 32'hFFFF00FF, 32'h80000100};
    bp_mode = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10};
    bp_exp  = '{4'b0100, 4'b1011, 4'b0111, 4'b1000, 4'b1101, 4'b0101};
    a_exp   = '{2'd1, 2'd1, 2'd1, 2'd0};

    rst = 1'b1;
    set_in(0, 1'b0, 32'h0, 2'b00);
    set_in(1, 1'b0, 32'h0, 2'b00);
    set_in(2, 1'b0, 32'h0, 2'b00);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_a", 32'(ifa.in_ready), 32'd0);
    chk("rst_in_ready_b", 32'(ifb.in_ready), 32'd0);
    chk("rst_out_valid_b", 32'(ifb.out_valid), 32'd0);
    chk("rst_out_data_b", 32'(ifb.out_data), 32'd0);
    chk("rst_out_mode_b", 32'(ifb.out_mode), 32'd0);
    chk("rst_out_valid_c", 32'(ifc.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two-input NAND equivalence.
    for (int i = 0; i < 4; i++) send(0, 32'(i), 2'b00, {2'b00, a_exp[i]}, 1'b1, a);
    drain(0);

    // All four modes on one word, back to back.
    send(1, 32'hFF7F0080, 2'b00, 4'b0111, 1'b1, a);
    send(1, 32'hFF7F0080, 2'b01, 4'b1000, 1'b1, a);
    send(1, 32'hFF7F0080, 2'b10, 4'b0010, 1'b1, a);
    send(1, 32'hFF7F0080, 2'b11, 4'b1101, 1'b1, a);
    drain(1);

    // Backpressure: out_ready low for cycles 3..6 of the stream.
    s0 = stall_cnt;
    fork
      begin
        int ab;
        for (int i = 0; i < 6; i++) send(1, bp_data[i], bp_mode[i], bp_exp[i], 1'b0, ab);
      end
      begin
        for (int k = 0; k < 12; k++) begin
          ifb.out_ready = !(k >= 3 && k <= 6);
          @(posedge clk);
          #1;
        end
      end
    join
    drain(1);
    chk("stall_cycles", 32'(stall_cnt - s0), 32'd4);

    // Bubbles: valid 1,0,1,0 gives out_valid 1,0,1,0 two cycles later.
    ifb.out_ready = 1'b1;
    send(1, 32'h01020408, 2'b11, 4'b1111, 1'b1, e0);
    idle(1);
    send(1, 32'hFFFEFF00, 2'b01, 4'b1010, 1'b1, a);
    idle(1);
    drain(1);
    idle(2);
    chk("bubble_0", 32'(ovlog[e0 + LAT_B + 0]), 32'd1);
    chk("bubble_1", 32'(ovlog[e0 + LAT_B + 1]), 32'd0);
    chk("bubble_2", 32'(ovlog[e0 + LAT_B + 2]), 32'd1);
    chk("bubble_3", 32'(ovlog[e0 + LAT_B + 3]), 32'd0);

    // Reset with two beats in flight.
    send(1, 32'h00000000, 2'b10, 4'b1111, 1'b0, a);
    send(1, 32'hFFFFFFFF, 2'b11, 4'b1111, 1'b0, a);
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    @(negedge clk);
    chk("midrst_in_ready", 32'(ifb.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ifb.out_valid), 32'd0);
    chk("midrst_out_data", 32'(ifb.out_data), 32'd0);
    chk("midrst_out_mode", 32'(ifb.out_mode), 32'd0);
    @(posedge clk);
    #1;
    send(1, 32'hFF00FF00, 2'b01, 4'b1010, 1'b1, a);
    drain(1);
    idle(4);

    // Padding on a non-power-of-two width.
    send(2, 32'h1F, 2'b01, 4'b0001, 1'b1, a);
    send(2, 32'h00, 2'b11, 4'b0000, 1'b1, a);
    send(2, 32'h1F, 2'b00, 4'b0000, 1'b1, a);
    send(2, 32'h00, 2'b10, 4'b0001, 1'b1, a);
    send(2, 32'h1E, 2'b01, 4'b0000, 1'b1, a);
    send(2, 32'h10, 2'b11, 4'b0001, 1'b1, a);
    drain(2);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
